// File: rtl/frame_guard_fifo_pkg.sv
// Shared video definitions for the frame guard FIFO: pixel width, frame size
// default, guard state encoding and the packed FIFO entry layout.
package frame_guard_fifo_pkg;

  localparam int PIX_W                = 12;
  localparam int ENTRY_W              = PIX_W + 2;
  localparam int FRAME_PIXELS_DEFAULT = 76800;
  localparam int PIX_CNT_W            = 17;

  typedef enum logic [0:0] {
    SEEK_SOP = 1'b0,
    IN_FRAME = 1'b1
  } guard_state_e;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [PIX_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/frame_guard_fifo_if.sv
// Pixel stream handshake bundle: upstream words in, downstream words out.
interface frame_guard_fifo_if;
  import frame_guard_fifo_pkg::*;

  logic [PIX_W-1:0] data_in;
  logic             sop_in;
  logic             eop_in;
  logic             valid_in;
  logic             ready_out;
  logic [PIX_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
  logic             valid_out;
  logic             ready_in;

  // master is the source/sink environment around the FIFO
  modport master (
    output data_in, sop_in, eop_in, valid_in, ready_in,
    input  ready_out, data_out, sop_out, eop_out, valid_out
  );

  modport slave (
    input  data_in, sop_in, eop_in, valid_in, ready_in,
    output ready_out, data_out, sop_out, eop_out, valid_out
  );

endinterface

// File: rtl/frame_guard_fifo_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; one extra pointer bit separates
// full from empty when the index bits match.
module stream_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + (AW+1)'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // storage is left unreset; empty pointers keep stale words invisible
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/frame_guard_fifo.sv
// Frame guard in front of a pixel FIFO: drops words outside a frame, repairs
// malformed frames so downstream always sees sop..eop, and counts outcomes.
module frame_guard_fifo
  import frame_guard_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_guard_fifo_if.slave    bus,
  output logic [15:0]          frame_count,
  output logic [7:0]           error_count,
  output logic                 frame_error
);

  localparam logic [PIX_CNT_W-1:0] FRAME_LEN = PIX_CNT_W'(FRAME_PIXELS);

  guard_state_e         state_q, state_d;
  logic [PIX_CNT_W-1:0] pixCnt_q, pixCnt_d;
  logic [PIX_CNT_W-1:0] pixNext;
  logic [15:0]          frameCount_q, frameCount_d;
  logic [7:0]           errorCount_q, errorCount_d;
  logic                 frameError_q, frameError_d;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  fifo_entry_t          wrEntry;
  fifo_entry_t          rdEntry;
  logic [ENTRY_W-1:0]   rdWord;

  assign accept  = bus.valid_in && !full;
  assign pop     = !empty && bus.ready_in;
  assign pixNext = pixCnt_q + PIX_CNT_W'(1);

  assign bus.ready_out = !full;
  assign bus.valid_out = !empty;
  assign rdEntry       = rdWord;
  assign bus.data_out  = rdEntry.data;
  assign bus.sop_out   = rdEntry.sop;
  assign bus.eop_out   = rdEntry.eop;

  stream_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wrEntry),
    .rdata_o (rdWord),
    .full_o  (full),
    .empty_o (empty)
  );

  // guard decision for the word being accepted this cycle; at most one
  // error is raised per word, and repaired words keep sop..eop well formed
  always_comb begin
    state_d      = state_q;
    pixCnt_d     = pixCnt_q;
    push         = 1'b0;
    frameError_d = 1'b0;
    wrEntry      = '{sop: bus.sop_in, eop: bus.eop_in, data: bus.data_in};
    if (accept) begin
      case (state_q)
        SEEK_SOP: begin
          if (bus.sop_in) begin
            push     = 1'b1;
            pixCnt_d = PIX_CNT_W'(1);
            if (!bus.eop_in) begin
              state_d = IN_FRAME;
            end else begin
              frameError_d = (FRAME_LEN != PIX_CNT_W'(1));
            end
          end
        end
        IN_FRAME: begin
          push     = 1'b1;
          pixCnt_d = pixNext;
          if (bus.sop_in) begin
            wrEntry.eop  = 1'b0;
            frameError_d = 1'b1;
            pixCnt_d     = PIX_CNT_W'(1);
          end else if (bus.eop_in) begin
            frameError_d = (pixNext != FRAME_LEN);
            state_d      = SEEK_SOP;
          end else if (pixNext == FRAME_LEN) begin
            wrEntry.eop  = 1'b1;
            frameError_d = 1'b1;
            state_d      = SEEK_SOP;
          end
        end
        default: state_d = SEEK_SOP;
      endcase
    end
  end

  always_comb begin
    frameCount_d = frameCount_q;
    errorCount_d = errorCount_q;
    if (pop && rdEntry.eop) begin
      frameCount_d = frameCount_q + 16'd1;
    end
    if (frameError_d && (errorCount_q != 8'hFF)) begin
      errorCount_d = errorCount_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEEK_SOP;
      pixCnt_q     <= '0;
      frameCount_q <= '0;
      errorCount_q <= '0;
      frameError_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixCnt_q     <= pixCnt_d;
      frameCount_q <= frameCount_d;
      errorCount_q <= errorCount_d;
      frameError_q <= frameError_d;
    end
  end

  assign frame_count = frameCount_q;
  assign error_count = errorCount_q;
  assign frame_error = frameError_q;

endmodule

// File: tb/tb_frame_guard_fifo.sv
// Randomized bench for frame_guard_fifo: a queue-based frame model is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_frame_guard_fifo;
  import frame_guard_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int FP    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] frame_count;
  logic [7:0]  error_count;
  logic        frame_error;

  frame_guard_fifo_if bus ();

  frame_guard_fifo #(
    .DEPTH        (DEPTH),
    .FRAME_PIXELS (FP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_count (frame_count),
    .error_count (error_count),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [13:0] modelQ[$];
  bit          mInFrame = 1'b0;
  int          mPix = 0;
  int          mFrames = 0;
  int          mErrors = 0;
  bit          mErrPulse = 1'b0;

  logic [13:0] outLog[$];
  int          errPulses = 0;
  bit          randReady = 1'b1;
  bit          forcedReady = 1'b1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void stepModel();
    bit acc;
    bit popped;
    bit err;
    acc    = bus.valid_in && (modelQ.size() < DEPTH);
    popped = (modelQ.size() > 0) && bus.ready_in;
    err    = 1'b0;
    if (popped) begin
      if (modelQ[0][12]) mFrames = (mFrames + 1) % 65536;
      void'(modelQ.pop_front());
    end
    if (acc) begin
      if (!mInFrame) begin
        if (bus.sop_in) begin
          modelQ.push_back({1'b1, bus.eop_in, bus.data_in});
          mPix = 1;
          if (bus.eop_in) err = (FP != 1);
          else mInFrame = 1'b1;
        end
      end else if (bus.sop_in) begin
        modelQ.push_back({1'b1, 1'b0, bus.data_in});
        err  = 1'b1;
        mPix = 1;
      end else if (bus.eop_in || (mPix + 1 == FP)) begin
        modelQ.push_back({1'b0, 1'b1, bus.data_in});
        err      = !(bus.eop_in && (mPix + 1 == FP));
        mInFrame = 1'b0;
      end else begin
        modelQ.push_back({1'b0, 1'b0, bus.data_in});
        mPix++;
      end
    end
    mErrPulse = err;
    if (err && mErrors < 255) mErrors++;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        modelQ.delete();
        mInFrame  = 1'b0;
        mPix      = 0;
        mFrames   = 0;
        mErrors   = 0;
        mErrPulse = 1'b0;
      end else begin
        stepModel();
      end
    end
  end

  // single compare process, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("valid_out", bus.valid_out, modelQ.size() != 0);
      checkOutput("ready_out", bus.ready_out, modelQ.size() < DEPTH);
      if (modelQ.size() != 0)
        checkOutput("head_word", {bus.sop_out, bus.eop_out, bus.data_out}, modelQ[0]);
      checkOutput("frame_count", frame_count, mFrames);
      checkOutput("error_count", error_count, mErrors);
      checkOutput("frame_error", frame_error, mErrPulse);
      if (frame_error) errPulses++;
    end
  end

  initial begin
    bus.ready_in = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      bus.ready_in = randReady ? ($urandom_range(0, 3) != 0) : forcedReady;
      #1;
      if (reset && bus.valid_out && bus.ready_in)
        outLog.push_back({bus.sop_out, bus.eop_out, bus.data_out});
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input bit sop, input bit eop, input logic [11:0] data);
    int waited;
    @(negedge clk);
    #1;
    if ($urandom_range(0, 4) == 0) begin
      @(negedge clk);
      #1;
    end
    bus.valid_in = 1'b1;
    bus.sop_in   = sop;
    bus.eop_in   = eop;
    bus.data_in  = data;
    waited = 0;
    while (!bus.ready_out && waited < 500) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.ready_out) checkOutput("accept_timeout", bus.ready_out, 1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
  endtask

  task automatic sendPixels(input int n, input bit withSop, input int eopAt, input int base);
    for (int i = 0; i < n; i++)
      applyStimulus(withSop && (i == 0), (i + 1) == eopAt, 12'(base + i));
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (bus.valid_out && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain", bus.valid_out, 0);
  endtask

  function automatic logic [13:0] logAt(input int idx);
    if (idx < outLog.size()) return outLog[idx];
    return 14'h0;
  endfunction

  initial begin
    int kind;
    int n;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    bus.data_in  = '0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid_out", bus.valid_out, 0);
    checkOutput("reset_ready_out", bus.ready_out, 1);
    checkOutput("reset_frame_count", frame_count, 0);
    checkOutput("reset_error_count", error_count, 0);
    checkOutput("reset_frame_error", frame_error, 0);
    #2 reset = 1'b1;

    // legal frame
    outLog.delete();
    sendPixels(16, 1, 16, 12'h100);
    waitDrain();
    checkOutput("legal_len", outLog.size(), 16);
    checkOutput("legal_first_sop", logAt(0)[13], 1);
    checkOutput("legal_last_eop", logAt(15)[12], 1);
    checkOutput("legal_frames", frame_count, 1);
    checkOutput("legal_errors", error_count, 0);

    // words before sop are dropped silently
    outLog.delete();
    errPulses = 0;
    sendPixels(3, 0, 0, 12'h200);
    sendPixels(16, 1, 16, 12'h300);
    waitDrain();
    checkOutput("presop_len", outLog.size(), 16);
    checkOutput("presop_first", logAt(0), 14'h2300);
    checkOutput("presop_pulses", errPulses, 0);
    checkOutput("presop_frames", frame_count, 2);

    // short frame
    outLog.delete();
    errPulses = 0;
    sendPixels(10, 1, 10, 12'h400);
    waitDrain();
    checkOutput("short_len", outLog.size(), 10);
    checkOutput("short_eop", logAt(9), 14'h1409);
    checkOutput("short_pulses", errPulses, 1);
    checkOutput("short_errors", error_count, 1);
    checkOutput("short_frames", frame_count, 3);

    // long frame without eop
    outLog.delete();
    sendPixels(20, 1, 0, 12'h500);
    waitDrain();
    checkOutput("long_len", outLog.size(), 16);
    checkOutput("long_forced_eop", logAt(15), 14'h150F);
    checkOutput("long_errors", error_count, 2);
    checkOutput("long_frames", frame_count, 4);

    // back-pressure fills the FIFO, then release
    outLog.delete();
    randReady   = 1'b0;
    forcedReady = 1'b0;
    sendPixels(16, 1, 16, 12'h600);
    repeat (2) @(negedge clk);
    checkOutput("bp_ready_low", bus.ready_out, 0);
    repeat (12) @(negedge clk);
    forcedReady = 1'b1;
    waitDrain();
    checkOutput("bp_len", outLog.size(), 16);
    for (int i = 0; i < 16; i++)
      checkOutput("bp_order", logAt(i)[11:0], 12'h600 + i);
    checkOutput("bp_frames", frame_count, 5);
    randReady = 1'b1;

    // randomized frame mix
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: sendPixels(16, 1, 16, $urandom_range(0, 4095));
        1: begin
          n = $urandom_range(1, 15);
          sendPixels(n, 1, n, $urandom_range(0, 4095));
        end
        2: sendPixels($urandom_range(16, 22), 1, 0, $urandom_range(0, 4095));
        3: begin
          sendPixels($urandom_range(2, 10), 1, 0, $urandom_range(0, 4095));
          sendPixels(16, 1, 16, $urandom_range(0, 4095));
        end
        default: sendPixels($urandom_range(1, 4), 0, 0, $urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        randReady   = 1'b0;
        forcedReady = 1'b0;
        repeat ($urandom_range(5, 25)) @(negedge clk);
        randReady = 1'b1;
      end
    end
    waitDrain();

    // reset mid-frame
    randReady   = 1'b0;
    forcedReady = 1'b0;
    sendPixels(2, 0, 0, 12'h700);
    sendPixels(5, 1, 0, 12'h710);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("rst_valid_out", bus.valid_out, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_error_count", error_count, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    checkOutput("rst_ready_out", bus.ready_out, 1);
    outLog.delete();
    randReady = 1'b1;
    sendPixels(2, 0, 0, 12'h800);
    sendPixels(16, 1, 16, 12'h900);
    waitDrain();
    checkOutput("rst_len", outLog.size(), 16);
    checkOutput("rst_first", logAt(0), 14'h2900);
    checkOutput("rst_frames", frame_count, 1);
    checkOutput("rst_errors", error_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
